alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Initiator side of the ALU operand/result interface. Accepts one command (A, B, op) per
//  valid/ready handshake and drives registered operands onto an external combinational ALU.
//  Captures Result/Carry/Zero one cycle later and returns them on a valid/ready response
//  channel. Rejects out-of-range opcodes without issuing them to the ALU.
// PARAMETERS
//  DATA_W  4  operand/result width; matches the ALU A, B and Result ports
//  OP_W    3  opcode width; matches the ALU control port
//  MAX_OP  4  highest legal opcode; opcodes above this are rejected
//  CNT_W   8  width of the completed-operation counter
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous active-low reset
//  cmd_valid    in   1       command offered
//  cmd_ready    out  1       sequencer can accept a command
//  cmd_a        in   DATA_W  operand A
//  cmd_b        in   DATA_W  operand B
//  cmd_op       in   OP_W    ALU opcode
//  alu_a        out  DATA_W  to ALU A (registered)
//  alu_b        out  DATA_W  to ALU B (registered)
//  alu_control  out  OP_W    to ALU control (registered)
//  alu_result   in   DATA_W  from ALU Result
//  alu_carry    in   1       from ALU Carry
//  alu_zero     in   1       from ALU Zero
//  rsp_valid    out  1       response held
//  rsp_ready    in   1       consumer accepts response
//  rsp_result   out  DATA_W  captured Result (0 on error)
//  rsp_carry    out  1       captured Carry (0 on error)
//  rsp_zero     out  1       captured Zero (0 on error)
//  rsp_err      out  1       1 = opcode > MAX_OP, not issued
//  done_count   out  CNT_W   responses completed (rsp_valid & rsp_ready), wraps at 2^CNT_W
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; all outputs 0 except cmd_ready; in-flight cmd dropped, no rsp.
//  - cmd_ready = (state==IDLE), driven combinationally from state. Accept = cmd_valid & cmd_ready.
//  - IDLE: on accept with cmd_op<=MAX_OP: load alu_a/alu_b/alu_control, go ISSUE.
//          on accept with cmd_op>MAX_OP: alu_* unchanged, rsp_err=1, rsp_result/carry/zero=0, go RESP.
//  - ISSUE (1 cycle): ALU settles; at clock edge capture alu_result/carry/zero into rsp_*, rsp_err=0, go RESP.
//  - RESP: rsp_valid=1; rsp_* stable until handshake. On rsp_ready: done_count+1, go IDLE.
//  - Latency: accept at edge N -> rsp_valid at N+2 (legal op), N+1 (rejected op). Max throughput 1 cmd / 3 clk.
//  - alu_* hold last issued values in IDLE/RESP (no glitching to ALU between ops).
//  - rsp_ready while rsp_valid=0 is ignored. cmd_valid outside IDLE is not accepted and must be held by source.
//  - done_count: wraps all-ones -> 0; counts rejected ops too.
//  - Reset asserted in ISSUE or RESP: response lost, done_count cleared.
// CONFIGURATION
//  ALU_SEQ_CHAIN_EN defined: adds input port cmd_chain (1 bit). Accept with cmd_chain=1 loads alu_a from
//    the last captured rsp_result (0 after reset or after a rejected op) instead of cmd_a; cmd_b/cmd_op as normal.
//  Undefined: no cmd_chain port; alu_a always loads cmd_a.
// TESTING
//  Bench ALU stub: Result=A^B, Carry=A[3], Zero=((A^B)==0).
//  1. Reset then A=3, B=1, op=0 -> alu_a=3/alu_b=1/alu_control=0 at N+1; rsp at N+2: result=2, carry=0, zero=0, err=0.
//  2. A=C, B=C, op=4, rsp_ready low 5 clk -> rsp_valid held, result=0, carry=1, zero=1 stable; cmd_ready=0 throughout.
//  3. op=5 -> rsp_valid at N+1, err=1, result=0; alu_control keeps prior value; done_count increments on handshake.
//  4. 256 back-to-back legal ops, rsp_ready tied 1 -> done_count wraps to 0; one accept per 3 clk.
//  5. rst_n low in ISSUE -> all outputs 0 immediately, cmd_ready=1, no rsp after release.
//  6. (ALU_SEQ_CHAIN_EN) A=4, B=2 then cmd_chain=1, B=6 -> second issue alu_a=6, rsp result=0, zero=1.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: ALU command/response sequencer. Defining ALU_SEQ_CHAIN_EN adds cmd_chain, which feeds the last result back into operand A.
module alu_op_sequencer #(
  parameter int DATA_W = 4,
  parameter int OP_W   = 3,
  parameter int MAX_OP = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [OP_W-1:0]   cmd_op,
`ifdef ALU_SEQ_CHAIN_EN
  input  logic              cmd_chain,
`endif
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_control,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_carry,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic [CNT_W-1:0]  done_count
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state, state_nxt;
  logic accept, bad_op;
  logic [DATA_W-1:0] a_src;
  assign accept = cmd_valid & cmd_ready;
  assign bad_op = cmd_op > OP_W'(MAX_OP);
`ifdef ALU_SEQ_CHAIN_EN
  // rsp_result is already 0 after reset or a rejected op, so it serves directly as the chain source
  assign a_src = cmd_chain ? rsp_result : cmd_a;
`else
  assign a_src = cmd_a;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE  ? (accept ? (bad_op ? RESP : ISSUE) : IDLE) :
                state == ISSUE ? RESP :
                rsp_ready      ? IDLE : RESP;
  always_comb begin
    cmd_ready = state == IDLE;
    rsp_valid = state == RESP;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= '0;
      rsp_result  <= '0;
      rsp_carry   <= 1'b0;
      rsp_zero    <= 1'b0;
      rsp_err     <= 1'b0;
      done_count  <= '0;
    end else begin
      if (accept && !bad_op) begin
        alu_a       <= a_src;
        alu_b       <= cmd_b;
        alu_control <= cmd_op;
      end
      if (accept && bad_op) begin
        rsp_result <= '0;
        rsp_carry  <= 1'b0;
        rsp_zero   <= 1'b0;
        rsp_err    <= 1'b1;
      end else if (state == ISSUE) begin
        rsp_result <= alu_result;
        rsp_carry  <= alu_carry;
        rsp_zero   <= alu_zero;
        rsp_err    <= 1'b0;
      end
      if (rsp_valid && rsp_ready) done_count <= done_count + 1'b1;
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: vector table, random ops against a spec-level model, throughput/wrap, reset-in-flight and chaining checks.
module tb_alu_op_sequencer;
  logic clk = 0, rst_n = 0, cmd_valid = 0, cmd_chain = 0, rsp_ready = 0;
  logic [3:0] cmd_a = 0, cmd_b = 0;
  logic [2:0] cmd_op = 0;
  logic cmd_ready, alu_carry, alu_zero, rsp_valid, rsp_carry, rsp_zero, rsp_err;
  logic [3:0] alu_a, alu_b, alu_result, rsp_result;
  logic [2:0] alu_control;
  logic [7:0] done_count;
  int n_chk = 0, n_fail = 0;
  int cnt;
  logic [2:0] last_ctrl;
  logic [3:0] last_res;

  alu_op_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
`ifdef ALU_SEQ_CHAIN_EN
    .cmd_chain(cmd_chain),
`endif
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_err(rsp_err), .done_count(done_count)
  );

  assign alu_result = alu_a ^ alu_b;
  assign alu_carry  = alu_a[3];
  assign alu_zero   = (alu_a ^ alu_b) == 4'd0;

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    cnt = 0;
    last_ctrl = 0;
    last_res = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_alu"}, {alu_a, alu_b, alu_control}, 0);
    chk({tag, "_rsp"}, {rsp_result, rsp_carry, rsp_zero, rsp_err}, 0);
    chk({tag, "_done_count"}, done_count, 0);
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op, input logic ch,
                        input int hold, input logic [3:0] er, input logic ec, input logic ez, input logic ee);
    int lat;
    logic legal;
    logic [3:0] ea;
    legal = op <= 3'd4;
    ea = ch ? last_res : a;
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_chain = ch; cmd_valid = 1; rsp_ready = 0;
    @(negedge clk);
    cmd_valid = 0; cmd_chain = 0; lat = 1;
    chk("cmd_ready_busy", cmd_ready, 0);
    if (legal) begin
      chk("alu_a", alu_a, ea);
      chk("alu_b", alu_b, b);
      chk("alu_control", alu_control, op);
      last_ctrl = op;
    end else chk("alu_control_kept", alu_control, last_ctrl);
    while (!rsp_valid && lat < 6) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, legal ? 2 : 1);
    for (int i = 0; i <= hold; i++) begin
      chk("rsp_valid_held", rsp_valid, 1);
      chk("cmd_ready_resp", cmd_ready, 0);
      chk("rsp_fields", {rsp_result, rsp_carry, rsp_zero, rsp_err}, {er, ec, ez, ee});
      if (i == hold) rsp_ready = 1;
      @(negedge clk);
    end
    rsp_ready = 0;
    cnt = (cnt + 1) % 256;
    last_res = ee ? 4'd0 : er;
    chk("done_count", done_count, cnt);
    chk("rsp_valid_drop", rsp_valid, 0);
    chk("cmd_ready_back", cmd_ready, 1);
  endtask

  typedef struct {
    logic [3:0] a, b;
    logic [2:0] op;
    int hold;
    logic [3:0] er;
    logic ec, ez, ee;
  } vec_t;

  vec_t vt[6];

  initial begin
    int acc, last, gap_bad;
    vt[0] = '{4'h3, 4'h1, 3'd0, 0, 4'h2, 1'b0, 1'b0, 1'b0};
    vt[1] = '{4'hC, 4'hC, 3'd4, 5, 4'h0, 1'b1, 1'b1, 1'b0};
    vt[2] = '{4'h7, 4'h2, 3'd5, 2, 4'h0, 1'b0, 1'b0, 1'b1};
    vt[3] = '{4'h9, 4'h6, 3'd2, 1, 4'hF, 1'b1, 1'b0, 1'b0};
    vt[4] = '{4'h5, 4'h5, 3'd7, 0, 4'h0, 1'b0, 1'b0, 1'b1};
    vt[5] = '{4'h0, 4'h0, 3'd1, 3, 4'h0, 1'b0, 1'b1, 1'b0};
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1;
    foreach (vt[i])
      run_op(vt[i].a, vt[i].b, vt[i].op, 1'b0, vt[i].hold, vt[i].er, vt[i].ec, vt[i].ez, vt[i].ee);
    for (int i = 0; i < 40; i++) begin
      logic [3:0] a, b;
      logic [2:0] op;
      logic bad;
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      op = 3'($urandom_range(0, 7));
      bad = op > 3'd4;
      run_op(a, b, op, 1'b0, int'($urandom_range(0, 2)),
             bad ? 4'd0 : a ^ b, bad ? 1'b0 : a[3], bad ? 1'b0 : (a ^ b) == 4'd0, bad);
    end
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    model_reset();
    cmd_a = 4'h5; cmd_b = 4'h3; cmd_op = 3'd1; cmd_valid = 1; rsp_ready = 1;
    acc = 0; last = -3; gap_bad = 0;
    for (int c = 0; c < 768; c++) begin
      if (cmd_ready) begin
        if (c - last != 3) gap_bad++;
        acc++;
        last = c;
      end
      if (c == 765) chk("count_before_wrap", done_count, 255);
      @(negedge clk);
    end
    cmd_valid = 0; rsp_ready = 0;
    chk("throughput_accepts", acc, 256);
    chk("throughput_gaps", gap_bad, 0);
    chk("count_wrapped", done_count, 0);
    chk("idle_after_burst", cmd_ready, 1);
    last_ctrl = 3'd1;
    last_res = 4'h6;
    run_op(4'hA, 4'h3, 3'd3, 1'b0, 0, 4'h9, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    cmd_a = 4'h8; cmd_b = 4'h1; cmd_op = 3'd2; cmd_valid = 1;
    @(negedge clk);
    cmd_valid = 0;
    chk("in_issue", cmd_ready, 0);
    rst_n = 0;
    #1;
    chk_reset_outputs("reset_in_issue");
    @(negedge clk);
    rst_n = 1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_rsp_after_reset", rsp_valid, 0);
    end
    run_op(4'h6, 4'h6, 3'd0, 1'b0, 1, 4'h0, 1'b0, 1'b1, 1'b0);
`ifdef ALU_SEQ_CHAIN_EN
    run_op(4'h4, 4'h2, 3'd0, 1'b0, 0, 4'h6, 1'b0, 1'b0, 1'b0);
    run_op(4'h1, 4'h6, 3'd0, 1'b1, 0, 4'h0, 1'b0, 1'b1, 1'b0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
